pft_bram_writer: RTL and testbench
==================================

Name: pft_bram_writer

Overview:
- Write-side controller for the banked PFT buffer (32 banks x 2^PFT_addr_width rows x PE_COL lanes).
- Accepts a valid/ready stream of PE_COL-wide feature rows and fills banks in order: bank 0 row 0 first, rows within a bank, then the next bank.
- Drives the buffer's per-bank write strobes, shared write address and write data.
- Maintains the per-bank valid mask that the read side uses for masking and centroid selection.

Parameters:
- PFT_addr_width, 5, row address width per bank.
- PFT_data_width, 8, bits per lane element.
- PE_COL, 16, lanes per row.
- PFT_bank, 32, number of banks; must be 32, matching the 5-bit bank index.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  pulse; latches cfg_banks and cfg_rows and begins a fill; ignored unless IDLE or DONE.
- cfg_banks  in  6  number of banks to fill, 1..32; 0 or >32 treated as 32.
- cfg_rows  in  PFT_addr_width+1  rows per bank, 1..32; 0 or >32 treated as 32.
- clear  in  1  pulse; zeroes the valid mask and aborts any fill.
- in_valid  in  1  input row valid.
- in_ready  out  1  high exactly when state is FILL.
- in_data  in  PFT_data_width*PE_COL  row data; lane k at [k*PFT_data_width +: PFT_data_width].
- write  out  PFT_bank  one-hot write strobe, registered.
- PFT_waddr  out  PFT_addr_width  write row address, registered.
- din  out  PFT_data_width*PE_COL  write data, registered.
- valid  out  PFT_bank  bank-filled mask, registered.
- busy  out  1  high in FILL.
- done  out  1  one-cycle pulse at fill completion.

Behaviour:
- Reset: state=IDLE. write, PFT_waddr, din, valid, done, busy and in_ready all 0. Bank and row counters 0.
- States:
  - IDLE -(start)-> FILL.
  - FILL -(last row of last bank accepted)-> DONE.
  - DONE -(start)-> FILL.
  - Any state -(clear)-> IDLE.
- On start: latch cfg_banks and cfg_rows after clamping; bank_cnt=0; row_cnt=0; valid cleared to 0 in the same edge.
- Handshake: a beat is accepted on a cycle with in_valid && in_ready.
- Write latency is 1 cycle. On the edge after acceptance:
  - write = one-hot(bank_cnt);
  - PFT_waddr = row_cnt;
  - din = in_data.
- write is all-zero in every cycle with no accepted beat on the previous edge; no spurious strobes.
- Counters on acceptance:
  - if row_cnt == rows-1: row_cnt=0, bank_cnt+1, and valid[bank_cnt] is set on the same edge its final write strobe appears;
  - otherwise row_cnt+1.
- Completion: on acceptance of the final row of bank banks-1, state goes to DONE. done pulses high on the same edge as that final write strobe. in_ready drops on that edge, so there is no extra acceptance.
- PFT_waddr never exceeds rows-1. bank_cnt never exceeds banks-1. No wrap into bank 0 during a fill.
- clear and start in the same cycle: clear wins; state=IDLE; valid=0.
- clear mid-fill:
  - the in-flight registered write (already-accepted beat) still appears next cycle;
  - no further beats are accepted;
  - valid=0 and stays 0, even if that write completes a bank.
- start while in FILL is ignored.
- Reset mid-fill: all outputs go to 0 immediately (asynchronous); no pending write is issued.
- in_valid with in_ready low is held off by the upstream; its data is not sampled.
- A valid bit, once set, holds until the next start, clear or rst.

Decomposition:
- Shared package holds:
  - PFT_ADDR_WIDTH=5, PFT_DATA_WIDTH=8, PE_COL=16, PFT_BANK=32, BANK_IDX_W=5;
  - state encoding IDLE=2'd0, FILL=2'd1, DONE=2'd2.
- One sub-module, decoder5x32: combinational 5-bit index to 32-bit one-hot. It is the inverse of the read side's 32x5 priority encoder and drives the write register input.

Test Plan:
- Reset then start with cfg_banks=2, cfg_rows=4, 8 back-to-back beats of data 0x00..07 replicated across lanes:
  - write=0x1 with waddr 0..3, then write=0x2 with waddr 0..3;
  - valid goes 0x1 after the 4th write and 0x3 after the 8th;
  - done pulses once, together with the 8th write; in_ready low afterwards.
- Same config with in_valid toggling every other cycle:
  - exactly 8 write strobes, each 1 cycle after its acceptance;
  - write=0 on idle cycles; final valid=0x3.
- cfg_banks=0, cfg_rows=0 (clamped to 32x32), 1024 beats:
  - last write is write=0x80000000 with waddr=31;
  - valid=0xFFFFFFFF; done after beat 1024.
- Fill cfg_banks=3, cfg_rows=2; assert clear after beat 3:
  - beat 3 is still written to bank1 addr0;
  - valid=0 and stays 0; state IDLE; in_ready=0.
- Assert rst mid-fill after beat 5 of a 2x4 fill:
  - write, valid, busy and done are 0 asynchronously;
  - a new start then refills from bank0 addr0.
- In DONE with valid=0x3, pulse start with cfg_banks=1, cfg_rows=1:
  - valid clears to 0; one beat gives write=0x1 with waddr=0; valid=0x1; done pulses.

Source files
------------

// File: rtl/pft_bram_writer_pkg.sv
// Shared definitions for the PFT buffer write-side controller.
// Holds the buffer geometry constants, the controller state encoding and a
// helper that turns a configured count (banks or rows) into its last index.
package pft_bram_writer_pkg;

    localparam int PFT_ADDR_WIDTH = 5;
    localparam int PFT_DATA_WIDTH = 8;
    localparam int PE_COL         = 16;
    localparam int PFT_BANK       = 32;
    localparam int BANK_IDX_W     = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } pft_state_e;

    // A count of 0 or anything above 32 means "all 32"; the controller only
    // ever needs the last valid index, which always fits in 5 bits.
    function automatic logic [4:0] last_index(input logic [5:0] cfg);
        if (cfg == 6'd0 || cfg > 6'd32) begin
            return 5'd31;
        end
        return cfg[4:0] - 5'd1;
    endfunction

endpackage

// File: rtl/pft_bram_writer_if.sv
// Bundle of the control, stream and buffer-write signals of the PFT writer.
//   start/cfg_banks/cfg_rows/clear : fill control from the host
//   in_valid/in_ready/in_data      : feature-row stream (valid/ready)
//   write/PFT_waddr/din            : registered buffer write port
//   valid/busy/done                : bank-filled mask and status
// master : the side that drives control and stream (host / upstream)
// slave  : the writer controller itself
interface pft_bram_writer_if
    import pft_bram_writer_pkg::*;
#(
    parameter int AW   = PFT_ADDR_WIDTH,
    parameter int DW   = PFT_DATA_WIDTH,
    parameter int COL  = PE_COL,
    parameter int BANK = PFT_BANK
) ();

    logic                start;
    logic [5:0]          cfg_banks;
    logic [AW:0]         cfg_rows;
    logic                clear;
    logic                in_valid;
    logic                in_ready;
    logic [DW*COL-1:0]   in_data;
    logic [BANK-1:0]     write;
    logic [AW-1:0]       PFT_waddr;
    logic [DW*COL-1:0]   din;
    logic [BANK-1:0]     valid;
    logic                busy;
    logic                done;

    modport master (
        output start, cfg_banks, cfg_rows, clear, in_valid, in_data,
        input  in_ready, write, PFT_waddr, din, valid, busy, done
    );

    modport slave (
        input  start, cfg_banks, cfg_rows, clear, in_valid, in_data,
        output in_ready, write, PFT_waddr, din, valid, busy, done
    );

endinterface

// File: rtl/pft_bram_writer_decoder5x32.sv
// 5-bit bank index to 32-bit one-hot bank select (purely combinational).
//   idx    : bank index 0..31
//   onehot : bit idx set, all others clear
module decoder5x32 (
    input  logic [4:0]  idx,
    output logic [31:0] onehot
);

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_dec
            assign onehot[gi] = (idx == 5'(gi));
        end
    endgenerate

endmodule

// File: rtl/pft_bram_writer.sv
// Write-side controller for the banked PFT buffer.
// Fills banks in order (all rows of bank 0, then bank 1, ...) from a
// valid/ready row stream, issuing one registered write per accepted row and
// maintaining the per-bank filled mask used by the read side.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : control, stream and buffer-write signals (slave side)
module pft_bram_writer
    import pft_bram_writer_pkg::*;
#(
    parameter int PFT_addr_width = PFT_ADDR_WIDTH,
    parameter int PFT_data_width = PFT_DATA_WIDTH,
    parameter int PE_COL_P       = PE_COL,
    parameter int PFT_bank       = PFT_BANK
) (
    input  logic               clk,
    input  logic               rst,
    pft_bram_writer_if.slave   bus
);

    localparam int ROW_W = PFT_data_width * PE_COL_P;

    pft_state_e                 state_reg, state_next;
    logic [BANK_IDX_W-1:0]      bank_cnt_reg, bank_last_reg;
    logic [PFT_addr_width-1:0]  row_cnt_reg, row_last_reg;
    logic [PFT_bank-1:0]        write_reg, valid_reg;
    logic [PFT_addr_width-1:0]  waddr_reg;
    logic [ROW_W-1:0]           din_reg;
    logic                       done_reg;

    logic [31:0]                bank_onehot;
    logic                       accept, row_wrap, last_bank, fill_end, start_ok;

    // A beat offered in the same cycle as clear still completes its
    // handshake (in_ready is high), so its write is issued; clear only stops
    // acceptance from the following cycle on.
    assign accept    = bus.in_valid && (state_reg == FILL);
    assign row_wrap  = (row_cnt_reg == row_last_reg);
    assign last_bank = (bank_cnt_reg == bank_last_reg);
    assign fill_end  = accept && row_wrap && last_bank;
    assign start_ok  = bus.start && !bus.clear &&
                       (state_reg == IDLE || state_reg == DONE);

    decoder5x32 u_dec (
        .idx    (bank_cnt_reg),
        .onehot (bank_onehot)
    );

    always_comb begin
        state_next = state_reg;
        if (bus.clear) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    if (bus.start) state_next = FILL;
                FILL:    if (fill_end)  state_next = DONE;
                DONE:    if (bus.start) state_next = FILL;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Bank/row position. The bank counter holds on the final row of the last
    // bank so it never wraps back into bank 0 during a fill.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_cnt_reg  <= '0;
            row_cnt_reg   <= '0;
            bank_last_reg <= '0;
            row_last_reg  <= '0;
        end else if (bus.clear) begin
            bank_cnt_reg <= '0;
            row_cnt_reg  <= '0;
        end else if (start_ok) begin
            bank_cnt_reg  <= '0;
            row_cnt_reg   <= '0;
            bank_last_reg <= last_index(bus.cfg_banks);
            row_last_reg  <= PFT_addr_width'(last_index(6'(bus.cfg_rows)));
        end else if (accept) begin
            if (row_wrap) begin
                row_cnt_reg <= '0;
                if (!last_bank) begin
                    bank_cnt_reg <= bank_cnt_reg + 1'b1;
                end
            end else begin
                row_cnt_reg <= row_cnt_reg + 1'b1;
            end
        end
    end

    // Registered write port and status. The valid bit and done pulse land on
    // the same edge as the write strobe of the row that completes them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_reg <= '0;
            waddr_reg <= '0;
            din_reg   <= '0;
            valid_reg <= '0;
            done_reg  <= 1'b0;
        end else begin
            write_reg <= accept ? PFT_bank'(bank_onehot) : '0;
            if (accept) begin
                waddr_reg <= row_cnt_reg;
                din_reg   <= bus.in_data;
            end
            done_reg <= fill_end && !bus.clear;
            if (bus.clear || start_ok) begin
                valid_reg <= '0;
            end else if (accept && row_wrap) begin
                valid_reg <= valid_reg | PFT_bank'(bank_onehot);
            end
        end
    end

    assign bus.write     = write_reg;
    assign bus.PFT_waddr = waddr_reg;
    assign bus.din       = din_reg;
    assign bus.valid     = valid_reg;
    assign bus.done      = done_reg;
    assign bus.busy      = (state_reg == FILL);
    assign bus.in_ready  = (state_reg == FILL);

endmodule

// File: tb/tb_pft_bram_writer.sv
// Directed self-checking bench for pft_bram_writer.
module tb_pft_bram_writer;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    pft_bram_writer_if bus ();

    pft_bram_writer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        iv;
        logic [7:0]  d;
        logic [31:0] w;
        logic [4:0]  a;
        logic [31:0] v;
        logic        dn;
        logic        rdy;
        logic        rs;
    } vec_t;

    vec_t vecs [25];

    function automatic vec_t mk(input logic iv, input logic [7:0] d,
                                input logic [31:0] w, input logic [4:0] a,
                                input logic [31:0] v, input logic dn,
                                input logic rdy, input logic rs);
        vec_t t;
        t.iv = iv; t.d = d; t.w = w; t.a = a;
        t.v = v; t.dn = dn; t.rdy = rdy; t.rs = rs;
        return t;
    endfunction

    function automatic logic [127:0] rep(input logic [7:0] b);
        return {16{b}};
    endfunction

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pulse(input logic [5:0] b, input logic [5:0] r);
        bus.start     = 1'b1;
        bus.cfg_banks = b;
        bus.cfg_rows  = r;
        step();
        bus.start = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.cfg_banks = '0;
        bus.cfg_rows = '0;
        bus.clear = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;

        // Back-to-back 2x4 fill, then a held-off beat in DONE.
        vecs[0]  = mk(1, 8'h00, 32'h1, 5'd0, 32'h0, 0, 1, 1);
        vecs[1]  = mk(1, 8'h01, 32'h1, 5'd1, 32'h0, 0, 1, 0);
        vecs[2]  = mk(1, 8'h02, 32'h1, 5'd2, 32'h0, 0, 1, 0);
        vecs[3]  = mk(1, 8'h03, 32'h1, 5'd3, 32'h1, 0, 1, 0);
        vecs[4]  = mk(1, 8'h04, 32'h2, 5'd0, 32'h1, 0, 1, 0);
        vecs[5]  = mk(1, 8'h05, 32'h2, 5'd1, 32'h1, 0, 1, 0);
        vecs[6]  = mk(1, 8'h06, 32'h2, 5'd2, 32'h1, 0, 1, 0);
        vecs[7]  = mk(1, 8'h07, 32'h2, 5'd3, 32'h3, 1, 0, 0);
        vecs[8]  = mk(1, 8'hEE, 32'h0, 5'd0, 32'h3, 0, 0, 0);
        // Same config, in_valid every other cycle, restarted from DONE.
        vecs[9]  = mk(1, 8'h10, 32'h1, 5'd0, 32'h0, 0, 1, 1);
        vecs[10] = mk(0, 8'h00, 32'h0, 5'd0, 32'h0, 0, 1, 0);
        vecs[11] = mk(1, 8'h11, 32'h1, 5'd1, 32'h0, 0, 1, 0);
        vecs[12] = mk(0, 8'h00, 32'h0, 5'd0, 32'h0, 0, 1, 0);
        vecs[13] = mk(1, 8'h12, 32'h1, 5'd2, 32'h0, 0, 1, 0);
        vecs[14] = mk(0, 8'h00, 32'h0, 5'd0, 32'h0, 0, 1, 0);
        vecs[15] = mk(1, 8'h13, 32'h1, 5'd3, 32'h1, 0, 1, 0);
        vecs[16] = mk(0, 8'h00, 32'h0, 5'd0, 32'h1, 0, 1, 0);
        vecs[17] = mk(1, 8'h14, 32'h2, 5'd0, 32'h1, 0, 1, 0);
        vecs[18] = mk(0, 8'h00, 32'h0, 5'd0, 32'h1, 0, 1, 0);
        vecs[19] = mk(1, 8'h15, 32'h2, 5'd1, 32'h1, 0, 1, 0);
        vecs[20] = mk(0, 8'h00, 32'h0, 5'd0, 32'h1, 0, 1, 0);
        vecs[21] = mk(1, 8'h16, 32'h2, 5'd2, 32'h1, 0, 1, 0);
        vecs[22] = mk(0, 8'h00, 32'h0, 5'd0, 32'h1, 0, 1, 0);
        vecs[23] = mk(1, 8'h17, 32'h2, 5'd3, 32'h3, 1, 0, 0);
        vecs[24] = mk(0, 8'h00, 32'h0, 5'd0, 32'h3, 0, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        check("rst_write", 128'(bus.write), 128'h0);
        check("rst_waddr", 128'(bus.PFT_waddr), 128'h0);
        check("rst_din", bus.din, 128'h0);
        check("rst_valid", 128'(bus.valid), 128'h0);
        check("rst_done", 128'(bus.done), 128'h0);
        check("rst_busy", 128'(bus.busy), 128'h0);
        check("rst_ready", 128'(bus.in_ready), 128'h0);
        $display("[TB] reset checked");
        rst = 1'b0;
        step();

        for (int i = 0; i < 25; i++) begin
            if (vecs[i].rs) begin
                start_pulse(6'd2, 6'd4);
                check($sformatf("v%0d_start_valid", i), 128'(bus.valid), 128'h0);
                check($sformatf("v%0d_start_ready", i), 128'(bus.in_ready), 128'h1);
            end
            bus.in_valid = vecs[i].iv;
            bus.in_data  = rep(vecs[i].d);
            step();
            check($sformatf("v%0d_write", i), 128'(bus.write), 128'(vecs[i].w));
            if (vecs[i].w != 32'h0) begin
                check($sformatf("v%0d_waddr", i), 128'(bus.PFT_waddr), 128'(vecs[i].a));
                check($sformatf("v%0d_din", i), bus.din, rep(vecs[i].d));
            end
            check($sformatf("v%0d_valid", i), 128'(bus.valid), 128'(vecs[i].v));
            check($sformatf("v%0d_done", i), 128'(bus.done), 128'(vecs[i].dn));
            check($sformatf("v%0d_ready", i), 128'(bus.in_ready), 128'(vecs[i].rdy));
            $display("[TB] vec %0d iv=%0b d=%02h -> write=%08h waddr=%0d valid=%08h done=%0b",
                     i, vecs[i].iv, vecs[i].d, bus.write, bus.PFT_waddr, bus.valid, bus.done);
        end
        bus.in_valid = 1'b0;

        // Clamped 32x32 fill.
        start_pulse(6'd0, 6'd0);
        for (int i = 0; i < 1024; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = rep(8'(i));
            step();
            check($sformatf("clamp%0d_write", i), 128'(bus.write), 128'(32'h1 << (i / 32)));
            check($sformatf("clamp%0d_waddr", i), 128'(bus.PFT_waddr), 128'(i % 32));
            check($sformatf("clamp%0d_done", i), 128'(bus.done), 128'(i == 1023));
            if (i == 31) check("clamp_valid_b0", 128'(bus.valid), 128'h1);
        end
        check("clamp_valid_all", 128'(bus.valid), 128'hFFFF_FFFF);
        step();
        check("clamp_after_write", 128'(bus.write), 128'h0);
        check("clamp_after_ready", 128'(bus.in_ready), 128'h0);
        bus.in_valid = 1'b0;
        $display("[TB] clamped 32x32 fill: valid=%08h", bus.valid);

        // Clear together with the third beat of a 3x2 fill.
        start_pulse(6'd3, 6'd2);
        bus.in_valid = 1'b1;
        bus.in_data  = rep(8'hA0);
        step();
        bus.in_data  = rep(8'hA1);
        step();
        bus.in_data  = rep(8'hAA);
        bus.clear    = 1'b1;
        step();
        bus.clear = 1'b0;
        check("clr_write", 128'(bus.write), 128'h2);
        check("clr_waddr", 128'(bus.PFT_waddr), 128'h0);
        check("clr_din", bus.din, rep(8'hAA));
        check("clr_valid", 128'(bus.valid), 128'h0);
        check("clr_ready", 128'(bus.in_ready), 128'h0);
        check("clr_busy", 128'(bus.busy), 128'h0);
        bus.in_data = rep(8'hAB);
        step();
        check("clr_next_write", 128'(bus.write), 128'h0);
        check("clr_next_valid", 128'(bus.valid), 128'h0);
        bus.in_valid = 1'b0;
        $display("[TB] clear mid-fill: valid=%08h ready=%0b", bus.valid, bus.in_ready);

        // Asynchronous reset after beat 5 of a 2x4 fill.
        start_pulse(6'd2, 6'd4);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.in_data = rep(8'(8'h30 + i));
            step();
        end
        check("rstm_pre_write", 128'(bus.write), 128'h2);
        check("rstm_pre_valid", 128'(bus.valid), 128'h1);
        rst = 1'b1;
        #1;
        check("rstm_write", 128'(bus.write), 128'h0);
        check("rstm_valid", 128'(bus.valid), 128'h0);
        check("rstm_busy", 128'(bus.busy), 128'h0);
        check("rstm_done", 128'(bus.done), 128'h0);
        check("rstm_ready", 128'(bus.in_ready), 128'h0);
        bus.in_valid = 1'b0;
        #1;
        rst = 1'b0;
        step();
        check("rstm_no_pending", 128'(bus.write), 128'h0);
        start_pulse(6'd2, 6'd4);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.in_data = rep(8'(8'h40 + i));
            step();
            if (i == 0) begin
                check("refill_write", 128'(bus.write), 128'h1);
                check("refill_waddr", 128'(bus.PFT_waddr), 128'h0);
            end
        end
        check("refill_valid", 128'(bus.valid), 128'h3);
        check("refill_done", 128'(bus.done), 128'h1);
        bus.in_valid = 1'b0;
        $display("[TB] reset mid-fill and refill: valid=%08h", bus.valid);

        // Restart from DONE with a 1x1 fill.
        start_pulse(6'd1, 6'd1);
        check("r11_valid0", 128'(bus.valid), 128'h0);
        check("r11_ready", 128'(bus.in_ready), 128'h1);
        bus.in_valid = 1'b1;
        bus.in_data  = rep(8'h5A);
        step();
        bus.in_valid = 1'b0;
        check("r11_write", 128'(bus.write), 128'h1);
        check("r11_waddr", 128'(bus.PFT_waddr), 128'h0);
        check("r11_valid", 128'(bus.valid), 128'h1);
        check("r11_done", 128'(bus.done), 128'h1);
        check("r11_ready_low", 128'(bus.in_ready), 128'h0);
        $display("[TB] 1x1 restart: write=%08h valid=%08h", bus.write, bus.valid);

        // Start and clear together: clear wins.
        bus.start = 1'b1;
        bus.clear = 1'b1;
        bus.cfg_banks = 6'd2;
        bus.cfg_rows  = 6'd4;
        step();
        bus.start = 1'b0;
        bus.clear = 1'b0;
        check("sc_busy", 128'(bus.busy), 128'h0);
        check("sc_valid", 128'(bus.valid), 128'h0);
        $display("[TB] start+clear: busy=%0b valid=%08h", bus.busy, bus.valid);

        // Start during FILL is ignored: the 2x4 fill continues at row 2.
        start_pulse(6'd2, 6'd4);
        bus.in_valid = 1'b1;
        bus.in_data  = rep(8'h60);
        step();
        step();
        bus.start = 1'b1;
        bus.cfg_banks = 6'd1;
        bus.cfg_rows  = 6'd1;
        bus.in_data   = rep(8'h62);
        step();
        bus.start = 1'b0;
        bus.in_valid = 1'b0;
        check("sf_write", 128'(bus.write), 128'h1);
        check("sf_waddr", 128'(bus.PFT_waddr), 128'h2);
        check("sf_busy", 128'(bus.busy), 128'h1);
        check("sf_done", 128'(bus.done), 128'h0);
        $display("[TB] start in FILL: waddr=%0d busy=%0b", bus.PFT_waddr, bus.busy);
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
